// File: rtl/oflow_core_write_sequencer_if.sv
// Write sequencer handshake bundle.
// master: core FSM / MEM buffer side, slave: sequencer.
interface oflow_core_write_sequencer_if #(
  parameter int unsigned PE_NUM   = 24,
  parameter int unsigned GROUP    = 4,
  parameter int unsigned MAX_BBOX = 128
);
  localparam int unsigned BBOX_W = $clog2(MAX_BBOX + 1);
  localparam int unsigned GPR    = (PE_NUM + GROUP - 1) / GROUP;
  localparam int unsigned ROWS   = (MAX_BBOX + PE_NUM - 1) / PE_NUM;
  localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned GRP_W  = (GPR > 1) ? $clog2(GPR) : 1;

  logic              start_write;
  logic [BBOX_W-1:0] num_of_bbox;
  logic              abort;
  logic              buf_ack;
  logic              write_req;
  logic [ROW_W-1:0]  row_sel;
  logic [GRP_W-1:0]  pe_grp_sel;
  logic [GROUP-1:0]  lane_mask;
  logic              busy;
  logic              done;

  modport master (
    output start_write, num_of_bbox, abort, buf_ack,
    input  write_req, row_sel, pe_grp_sel, lane_mask,
    input  busy, done
  );

  modport slave (
    input  start_write, num_of_bbox, abort, buf_ack,
    output write_req, row_sel, pe_grp_sel, lane_mask,
    output busy, done
  );
endinterface

// File: rtl/oflow_core_write_sequencer.sv
// Core PE-array write sequencer: walks bbox rows and
// PE groups, one req/ack beat per group, then pulses done.
module oflow_core_write_sequencer #(
  parameter int unsigned PE_NUM   = 24,
  parameter int unsigned GROUP    = 4,
  parameter int unsigned MAX_BBOX = 128,
  parameter int unsigned BEAT_GAP = 3
) (
  input logic clk,
  input logic reset_N,
  oflow_core_write_sequencer_if.slave bus
);
  localparam int unsigned BBOX_W = $clog2(MAX_BBOX + 1);
  localparam int unsigned GPR    = (PE_NUM + GROUP - 1) / GROUP;
  localparam int unsigned ROWS   = (MAX_BBOX + PE_NUM - 1) / PE_NUM;
  localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned GRP_W  = (GPR > 1) ? $clog2(GPR) : 1;
  localparam int unsigned GAP_W  = (BEAT_GAP > 1) ? $clog2(BEAT_GAP) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_REQ    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  localparam logic [1:0] S_GO = (BEAT_GAP == 0) ? S_REQ : S_SETTLE;

  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'((BEAT_GAP > 0) ? BEAT_GAP - 1 : 0);
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(GPR - 1);
  localparam logic [BBOX_W-1:0] MAX_N = BBOX_W'(MAX_BBOX);

  logic [1:0]        state;
  logic [GAP_W-1:0]  gap_cnt;
  logic [BBOX_W-1:0] num_q;
  logic [ROW_W-1:0]  row_q;
  logic [GRP_W-1:0]  grp_q;
  logic [GROUP-1:0]  mask_q;

  logic [BBOX_W-1:0] start_num;
  logic              wrap;
  logic [ROW_W-1:0]  nrow;
  logic [GRP_W-1:0]  ngrp;
  logic [31:0]       next_base;
  logic              last;
  logic [GROUP-1:0]  mask_start;
  logic [GROUP-1:0]  mask_next;

  function automatic logic [GROUP-1:0] lanes_f(
    input logic [31:0] num,
    input logic [31:0] row,
    input logic [31:0] grp
  );
    logic [31:0] base;
    logic [31:0] rem;
    logic [31:0] room;
    logic [31:0] lanes;
    logic [GROUP-1:0] m;
    base  = row * PE_NUM + grp * GROUP;
    rem   = (num > base) ? num - base : 32'd0;
    room  = PE_NUM - grp * GROUP;
    lanes = GROUP;
    if (rem < lanes) lanes = rem;
    if (room < lanes) lanes = room;
    m = '0;
    for (int i = 0; i < GROUP; i++)
      m[i] = (32'(i) < lanes);
    return m;
  endfunction

  // Next-beat position, last-beat detect and lane masks.
  always_comb begin
    start_num = (bus.num_of_bbox > MAX_N) ?
                MAX_N : bus.num_of_bbox;
    wrap = (grp_q == GRP_LAST);
    nrow = wrap ? row_q + ROW_W'(1) : row_q;
    ngrp = wrap ? '0 : grp_q + GRP_W'(1);
    if (wrap)
      next_base = (32'(row_q) + 32'd1) * PE_NUM;
    else
      next_base = 32'(row_q) * PE_NUM +
                  (32'(grp_q) + 32'd1) * GROUP;
    last = (32'(num_q) <= next_base);
    mask_start = lanes_f(32'(start_num), 32'd0, 32'd0);
    mask_next  = lanes_f(32'(num_q), 32'(nrow), 32'(ngrp));
  end

  // Sequencer state, beat position and registered selects.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state   <= S_IDLE;
      gap_cnt <= '0;
      num_q   <= '0;
      row_q   <= '0;
      grp_q   <= '0;
      mask_q  <= '0;
    end else if (bus.abort && state != S_IDLE) begin
      state   <= S_IDLE;
      gap_cnt <= '0;
      num_q   <= '0;
      row_q   <= '0;
      grp_q   <= '0;
      mask_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start_write) begin
            num_q   <= start_num;
            row_q   <= '0;
            grp_q   <= '0;
            gap_cnt <= '0;
            mask_q  <= mask_start;
            state   <= (start_num == '0) ? S_DONE : S_GO;
          end
        end
        S_SETTLE: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= S_REQ;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        S_REQ: begin
          if (bus.buf_ack) begin
            if (last) begin
              row_q  <= '0;
              grp_q  <= '0;
              mask_q <= '0;
              state  <= S_DONE;
            end else begin
              row_q  <= nrow;
              grp_q  <= ngrp;
              mask_q <= mask_next;
              state  <= S_GO;
            end
          end
        end
        default: begin
          num_q <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.write_req  = (state == S_REQ);
  assign bus.busy       = (state != S_IDLE);
  assign bus.done       = (state == S_DONE);
  assign bus.row_sel    = row_q;
  assign bus.pe_grp_sel = grp_q;
  assign bus.lane_mask  = mask_q;
endmodule
